// File: rtl/glb_pkg.sv
// Shared GLB cluster constants and types.
// Used by the iact address SRAM read-side logic.
package glb_pkg;

    localparam int ADDR_W               = 7;
    localparam int LUT_IDX_W            = 10;
    localparam int IACT_ADDR_SRAM_DEPTH = 512;
    localparam int IACT_ADDR_LUT_DEPTH  = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        PAUSE,
        DRAIN,
        DONE
    } readerState_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// The head entry is visible on popData whenever empty is low.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       pushData,
    input  logic                   pop,
    output logic [WIDTH-1:0]       popData,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             full;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    // An overflow means the caller's credit accounting is broken.
    assert property (@(posedge clock) disable iff (!reset)
        !(push && full && !pop));

endmodule

// File: rtl/iact_addr_stream_reader.sv
// Read-side controller for the iact address SRAM: walks stream indices,
// forwards address words with one EOS beat per stream to the PE channel.
module iact_addr_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = glb_pkg::ADDR_W,
    parameter int LUT_IDX_W  = glb_pkg::LUT_IDX_W,
    parameter int CNT_W      = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           num_streams,
    output logic                 busy,
    output logic                 done,
    output logic                 all_end,
    output logic                 sram_read_en,
    output logic [LUT_IDX_W-1:0] sram_read_addr,
    output logic                 sram_data_out_ready,
    input  logic                 sram_data_out_valid,
    input  logic [ADDR_W-1:0]    sram_data_out,
    output logic                 addr_valid,
    input  logic                 addr_ready,
    output logic [ADDR_W-1:0]    addr_data,
    output logic                 addr_eos
);

    import glb_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] ISSUE_LIMIT = (CW+1)'(FIFO_DEPTH - 2);

    readerState_t         state;
    readerState_t         nextState;
    logic [LUT_IDX_W-1:0] streamIdx;
    logic [4:0]           numStreamsQ;
    logic [CNT_W-1:0]     skipCnt;
    logic [CNT_W-1:0]     deliveredCnt;
    logic                 inflight;
    logic                 allEnd;
    logic                 readEn;

    logic [CW-1:0]        fifoCount;
    logic                 fifoEmpty;
    logic                 fifoPush;
    logic                 fifoPop;
    logic [ADDR_W:0]      fifoIn;
    logic [ADDR_W:0]      fifoOut;

    logic [CW:0]          occupied;
    logic                 canIssue;
    logic                 beatValid;
    logic                 skipping;
    logic                 zeroWord;
    logic                 terminator;
    logic                 eosBeat;
    logic                 dataBeat;
    logic                 lastStream;
    logic                 finishing;
    logic                 fifoDrained;
    logic                 startOk;

    // Credit check: the read issued now lands next cycle, so count it too.
    assign occupied = {1'b0, fifoCount} + (CW+1)'(inflight);
    assign canIssue = (occupied <= ISSUE_LIMIT);

    assign startOk    = (state == IDLE) && start;
    assign beatValid  = (state == ISSUE) && sram_data_out_valid;
    assign skipping   = (skipCnt != '0);
    assign zeroWord   = (sram_data_out == '0);
    assign terminator = beatValid && !skipping && zeroWord
                        && (deliveredCnt == '0);
    assign eosBeat    = beatValid && !skipping && zeroWord
                        && (deliveredCnt != '0);
    assign dataBeat   = beatValid && !skipping && !zeroWord;

    assign fifoPush = eosBeat || dataBeat;
    assign fifoIn   = {eosBeat, sram_data_out};
    assign fifoPop  = addr_valid && addr_ready;

    assign lastStream  = ((streamIdx + LUT_IDX_W'(1))
                          == LUT_IDX_W'(numStreamsQ));
    assign finishing   = lastStream || allEnd;
    assign fifoDrained = fifoEmpty
                         || ((fifoCount == CW'(1)) && fifoPop);

    always_comb begin
        nextState = state;
        readEn    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = (num_streams == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Reads on past a zero; the stray beat dies in DRAIN.
                readEn = canIssue;
                if (eosBeat || terminator) begin
                    nextState = DRAIN;
                end else if (!canIssue) begin
                    nextState = PAUSE;
                end
            end
            PAUSE: begin
                if (canIssue) nextState = ISSUE;
            end
            DRAIN: begin
                if (!finishing) begin
                    nextState = ISSUE;
                end else if (fifoDrained) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            streamIdx    <= '0;
            numStreamsQ  <= '0;
            skipCnt      <= '0;
            deliveredCnt <= '0;
            inflight     <= 1'b0;
            allEnd       <= 1'b0;
        end else begin
            state    <= nextState;
            inflight <= readEn;
            if (startOk) begin
                numStreamsQ  <= num_streams;
                streamIdx    <= '0;
                allEnd       <= 1'b0;
                skipCnt      <= '0;
                deliveredCnt <= '0;
            end
            // The SRAM rewinds to word 0 while read_en is low.
            if (state == PAUSE) begin
                skipCnt <= deliveredCnt;
            end
            if (beatValid) begin
                if (skipping) begin
                    skipCnt <= skipCnt - CNT_W'(1);
                end else if (dataBeat) begin
                    deliveredCnt <= deliveredCnt + CNT_W'(1);
                end else begin
                    deliveredCnt <= '0;
                end
            end
            if (terminator) begin
                allEnd <= 1'b1;
            end
            if ((state == DRAIN) && !finishing) begin
                streamIdx <= streamIdx + LUT_IDX_W'(1);
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (fifoIn),
        .pop      (fifoPop),
        .popData  (fifoOut),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign sram_read_en        = readEn;
    assign sram_data_out_ready = readEn;
    assign sram_read_addr      = streamIdx;
    assign busy       = (state inside {ISSUE, PAUSE, DRAIN});
    assign done       = (state == DONE);
    assign all_end    = allEnd;
    assign addr_valid = !fifoEmpty;
    assign addr_data  = fifoEmpty ? '0 : fifoOut[ADDR_W-1:0];
    assign addr_eos   = !fifoEmpty && fifoOut[ADDR_W];

endmodule

// File: tb/tb_iact_addr_stream_reader.sv
// Scoreboard bench for iact_addr_stream_reader against a
// behavioural SRAM that rewinds its word index when read_en drops.
module tb_iact_addr_stream_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] num_streams = '0;
    logic       busy;
    logic       done;
    logic       all_end;
    logic       sram_read_en;
    logic [9:0] sram_read_addr;
    logic       sram_data_out_ready;
    logic       sramValid = 1'b0;
    logic [6:0] sramData = '0;
    logic       addr_valid;
    logic       addr_ready = 1'b0;
    logic [6:0] addr_data;
    logic       addr_eos;

    always #5 clock = ~clock;

    iact_addr_stream_reader dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .num_streams         (num_streams),
        .busy                (busy),
        .done                (done),
        .all_end             (all_end),
        .sram_read_en        (sram_read_en),
        .sram_read_addr      (sram_read_addr),
        .sram_data_out_ready (sram_data_out_ready),
        .sram_data_out_valid (sramValid),
        .sram_data_out       (sramData),
        .addr_valid          (addr_valid),
        .addr_ready          (addr_ready),
        .addr_data           (addr_data),
        .addr_eos            (addr_eos)
    );

    // SRAM model: 1-cycle latency, index resets whenever read_en is low.
    logic [6:0] mem [8][32];
    int         ptr = 0;

    always @(posedge clock) begin
        if (sram_read_en) begin
            sramValid <= 1'b1;
            sramData  <= mem[sram_read_addr[2:0]][ptr[4:0]];
            if (ptr < 31) ptr <= ptr + 1;
        end else begin
            sramValid <= 1'b0;
            sramData  <= '0;
            ptr       <= 0;
        end
    end

    int         totalCnt = 0;
    int         badCnt = 0;
    logic [7:0] expQ [$];
    logic       expAllEnd;
    int         cyc = 0;
    int         popCount = 0;
    int         popBase = 0;
    int         lastPop = -1;
    int         doneCyc = -1;
    int         readCount = 0;
    int         readsAt [8];
    int         busySeen = 0;
    int         readyBad = 0;
    int         gapCount = 0;
    int         gapLen = 0;
    int         lastGap = 0;
    bit         seenEn = 1'b0;
    int         readyMode = 0;
    int         holdCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive ready, then sample every DUT output at negedge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clock);
        cyc++;
        case (readyMode)
            0: addr_ready = 1'b0;
            1: addr_ready = 1'b1;
            2: begin
                holdCnt = (popCount == popBase) ? 0 : holdCnt;
                if (popCount == popBase) addr_ready = 1'b1;
                else if (holdCnt < 10) begin
                    addr_ready = 1'b0;
                    holdCnt++;
                end else addr_ready = 1'b1;
            end
            default: addr_ready = 1'($urandom_range(0, 1));
        endcase
        if (readyMode != 2) holdCnt = 0;
        if (reset) begin
            if (addr_valid && addr_ready) begin
                popCount++;
                lastPop = cyc;
                if (expQ.size() == 0) begin
                    checkVal("extra beat", {23'd0, addr_eos, addr_data},
                             32'hffff_ffff);
                end else begin
                    e = expQ.pop_front();
                    checkVal("beat", {24'd0, addr_eos, addr_data},
                             {24'd0, e});
                end
            end
            if (done) doneCyc = cyc;
            if (sram_read_en) begin
                readCount++;
                readsAt[sram_read_addr[2:0]]++;
            end
            if (sram_data_out_ready !== sram_read_en) readyBad++;
            if (busy) busySeen++;
            if (!busy) begin
                seenEn = 1'b0;
                gapLen = 0;
            end else if (sram_read_en) begin
                if (gapLen > 0) begin
                    gapCount++;
                    lastGap = gapLen;
                end
                gapLen = 0;
                seenEn = 1'b1;
            end else if (seenEn) begin
                gapLen++;
            end
        end
    endtask

    task automatic clearMem();
        for (int s = 0; s < 8; s++)
            for (int i = 0; i < 32; i++) mem[s][i] = '0;
    endtask

    // Reference: words up to each zero, an EOS per stream, and a stop
    // at a stream whose very first word is zero.
    task automatic buildExpected(input int ns);
        expAllEnd = 1'b0;
        for (int s = 0; s < ns; s++) begin
            if (mem[s][0] == '0) begin
                expAllEnd = 1'b1;
                break;
            end
            for (int i = 0; i < 32; i++) begin
                if (mem[s][i] == '0) begin
                    expQ.push_back(8'h80);
                    break;
                end
                expQ.push_back({1'b0, mem[s][i]});
            end
        end
    endtask

    task automatic pulseStart(input int ns);
        num_streams = 5'(ns);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n;
        for (n = 0; n < limit; n++) begin
            tick();
            if (done) break;
        end
        if (n == limit) checkVal("done timeout", 0, 1);
    endtask

    initial begin
        int rd0, rd1, rd2, gb, rb, bb, nb;
        clearMem();
        for (int i = 0; i < 8; i++) readsAt[i] = 0;
        tick();
        tick();
        checkVal("rst addr_valid", 32'(addr_valid), 0);
        checkVal("rst busy", 32'(busy), 0);
        checkVal("rst done", 32'(done), 0);
        checkVal("rst read_en", 32'(sram_read_en), 0);
        checkVal("rst read_addr", 32'(sram_read_addr), 0);
        reset = 1'b1;
        tick();

        // 1: two short streams, ready held high
        mem[0][0] = 7'd3; mem[0][1] = 7'd5;
        mem[1][0] = 7'd7;
        buildExpected(2);
        readyMode = 1;
        rd0 = readsAt[0]; rd1 = readsAt[1]; rd2 = readsAt[2];
        gb = gapCount;
        pulseStart(2);
        waitDone(200);
        checkVal("t1 done after pop", 32'(doneCyc - lastPop), 1);
        tick();
        checkVal("t1 done pulse", 32'(done), 0);
        checkVal("t1 queue empty", 32'(expQ.size()), 0);
        checkVal("t1 addr0 read", 32'(readsAt[0] > rd0), 1);
        checkVal("t1 addr1 read", 32'(readsAt[1] > rd1), 1);
        checkVal("t1 addr2 unread", 32'(readsAt[2] - rd2), 0);
        checkVal("t1 gap count", 32'(gapCount - gb), 1);
        checkVal("t1 gap length", 32'(lastGap), 1);
        checkVal("t1 all_end", 32'(all_end), 0);

        // 2: backpressure forces PAUSE and replay-skip
        clearMem();
        for (int i = 0; i < 6; i++) mem[0][i] = 7'(i + 1);
        buildExpected(1);
        popBase = popCount;
        gb = gapCount;
        readyMode = 2;
        pulseStart(1);
        waitDone(400);
        tick();
        checkVal("t2 queue empty", 32'(expQ.size()), 0);
        checkVal("t2 beats", 32'(popCount - popBase), 7);
        checkVal("t2 pause seen", 32'(gapCount > gb), 1);

        // 3: double-zero terminator in stream 1
        clearMem();
        mem[0][0] = 7'd4; mem[0][1] = 7'd9;
        mem[2][0] = 7'd6;
        buildExpected(3);
        readyMode = 1;
        rd2 = readsAt[2];
        pulseStart(3);
        waitDone(200);
        tick();
        checkVal("t3 queue empty", 32'(expQ.size()), 0);
        checkVal("t3 all_end", 32'(all_end), 32'(expAllEnd));
        checkVal("t3 addr2 unread", 32'(readsAt[2] - rd2), 0);

        // 4: zero streams
        rb = readCount;
        bb = busySeen;
        pulseStart(0);
        checkVal("t4 done next", 32'(done), 1);
        checkVal("t4 busy", 32'(busy), 0);
        checkVal("t4 all_end clr", 32'(all_end), 0);
        repeat (3) tick();
        checkVal("t4 no reads", 32'(readCount - rb), 0);
        checkVal("t4 never busy", 32'(busySeen - bb), 0);

        // 5: async reset with the FIFO partly full
        clearMem();
        for (int i = 0; i < 6; i++) mem[0][i] = 7'(i + 1);
        buildExpected(1);
        readyMode = 0;
        pulseStart(1);
        repeat (12) tick();
        checkVal("t5 fifo head valid", 32'(addr_valid), 1);
        checkVal("t5 fifo head data", 32'(addr_data), 1);
        #2 reset = 1'b0;
        #1;
        checkVal("t5 addr_valid", 32'(addr_valid), 0);
        checkVal("t5 addr_data", 32'(addr_data), 0);
        checkVal("t5 busy", 32'(busy), 0);
        checkVal("t5 done", 32'(done), 0);
        checkVal("t5 read_en", 32'(sram_read_en), 0);
        expQ.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        clearMem();
        mem[0][0] = 7'd5;
        mem[1][0] = 7'd8; mem[1][1] = 7'd2;
        buildExpected(2);
        readyMode = 1;
        rd0 = readsAt[0];
        pulseStart(2);
        waitDone(200);
        tick();
        checkVal("t5 replay queue", 32'(expQ.size()), 0);
        checkVal("t5 stream0 read", 32'(readsAt[0] > rd0), 1);

        // 6: random lengths, random backpressure
        clearMem();
        for (int s = 0; s < 4; s++) begin
            int len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                mem[s][i] = 7'($urandom_range(1, 127));
        end
        buildExpected(4);
        nb = expQ.size();
        popBase = popCount;
        readyMode = 3;
        pulseStart(4);
        waitDone(4000);
        readyMode = 1;
        repeat (2) tick();
        checkVal("t6 queue empty", 32'(expQ.size()), 0);
        checkVal("t6 beats", 32'(popCount - popBase), 32'(nb));
        checkVal("t6 all_end", 32'(all_end), 32'(expAllEnd));
        checkVal("data_out_ready tracks read_en", 32'(readyBad), 0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/iact_addr_stream_reader.md
Name: iact_addr_stream_reader

Overview:
- Read-side controller for the iact address SRAM in the GLB cluster.
- Walks stream indices 0..num_streams-1 and drives the SRAM read port (read_en, read_addr, data_out_ready).
- Captures the 1-cycle-latency read data and forwards address words to the PE-side valid/ready channel, one end-of-stream beat per stream.
- Absorbs downstream backpressure with a small FIFO plus replay-skip, because the SRAM restarts its stream index whenever read_en drops.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries (power of 2, minimum 4).
- ADDR_W, 7, address word width.
- LUT_IDX_W, 10, width of the stream index driven on sram_read_addr.
- CNT_W, 9, width of the per-stream beat and replay counters (covers 512-deep SRAM).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a pass over all streams; ignored while busy.
- num_streams  in  5  number of streams in the pass, 1..31; 0 means done immediately.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse when the pass completes.
- all_end  out  1  sticky until next start; set when the double-zero terminator is hit early.
- sram_read_en  out  1  SRAM read_en.
- sram_read_addr  out  LUT_IDX_W  SRAM read_addr (current stream index).
- sram_data_out_ready  out  1  SRAM data_out_ready; always equals sram_read_en.
- sram_data_out_valid  in  1  SRAM data_out_valid.
- sram_data_out  in  ADDR_W  SRAM data_out.
- addr_valid  out  1  downstream beat valid.
- addr_ready  in  1  downstream ready.
- addr_data  out  ADDR_W  address word; 0 on EOS beats.
- addr_eos  out  1  marks the end-of-stream beat.

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0; FIFO empty; counters 0; sram_read_addr 0.
- States:
  - IDLE: start & num_streams!=0 → ISSUE with stream_idx=0; start & num_streams==0 → done pulse, stay IDLE.
  - ISSUE: sram_read_en=1 while room = FIFO_DEPTH - fifo_count - inflight >= 2, where inflight = read_en registered last cycle.
    - room<2 → PAUSE.
    - Valid beat with data 0 → DRAIN.
  - PAUSE: read_en=0. SRAM resets its index, so set skip_cnt := delivered_cnt. Return to ISSUE when room>=2. Minimum 1 cycle in PAUSE.
  - DRAIN: read_en=0 for exactly 1 cycle so the SRAM zero FSM clears.
    - Then stream_idx+1 == num_streams → wait for FIFO empty → DONE.
    - Otherwise stream_idx++ → ISSUE.
  - DONE: done=1 for one cycle → IDLE.
- Return beats (sram_data_out_valid=1):
  - skip_cnt>0: drop the beat, skip_cnt--.
  - Else nonzero data: push {data, eos=0}, delivered_cnt++.
  - Else zero: push {0, eos=1}, clear delivered_cnt.
  - Exception: zero on the first beat of a stream (delivered_cnt==0, no skip) is the double-zero terminator. Push nothing, set all_end, go to DONE once the FIFO is empty. Remaining streams are not read.
- Beat counting: push happens the cycle valid is seen; first read of a stream returns 2 cycles after ISSUE entry (read_en cycle + 1).
- FIFO: FIFO_DEPTH entries of ADDR_W+1 bits; addr_valid = !empty; pop on addr_valid & addr_ready. Push and pop in the same cycle are both honored. The room rule guarantees no overflow; an overflow is an assertion failure.
- sram_read_addr is held stable during ISSUE/PAUSE/DRAIN of a stream.
- start while busy: ignored.
- Reset mid-pass: immediate return to IDLE, FIFO flushed, no done.
- Throughput: 1 beat/cycle with addr_ready held high, no PAUSE entered.

Decomposition:
- Shared package (glb_pkg): ADDR_W, LUT_IDX_W, IACT_ADDR_SRAM_DEPTH=512, IACT_ADDR_LUT_DEPTH=32, reader state enum {IDLE, ISSUE, PAUSE, DRAIN, DONE}.
- One sub-module, sync_fifo_fwft (parameterised width/depth; count output, first-word fall-through), instantiated for the {eos,data} queue.

Test Plan:
1. SRAM model streams S0=[3,5,0], S1=[7,0], num_streams=2, addr_ready=1 → beats 3,5,EOS,7,EOS; done 1 cycle after last pop; sram_read_addr 0 then 1; a 1-cycle read_en gap between streams.
2. S0=[1,2,3,4,5,6,0], addr_ready=0 for 10 cycles after the first beat → PAUSE entered; on resume exactly 1,2,3,4,5,6,EOS delivered; no duplicates; skip_cnt drops replayed beats.
3. num_streams=3, S1 first word 0 (terminator) → beats S0 then done; all_end=1; sram_read_addr never reaches 2.
4. num_streams=0 with start → done next cycle; busy stays 0; no SRAM reads.
5. Reset asserted mid-stream (FIFO holding 3 entries) → all outputs 0 asynchronously; a new start replays from stream 0 correctly.
6. addr_ready randomly toggled 50% over 4 streams of lengths 1..20 → output equals reference concatenation; FIFO never overflows.
